// File: rtl/alu_cu.sv
// ALU control unit for the RV32I datapath: decodes aluop/funct3/funct7 into a
// 4-bit ALU select, combinationally and through an ID/EX register with stall/flush.
module alu_cu #(
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        aluop,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic              en,
   input  logic              flush,
   output logic [CTRL_W-1:0] alu_control,
   output logic              illegal,
   output logic [CTRL_W-1:0] alu_control_q,
   output logic              illegal_q
);

   localparam logic [2:0] R_TYPE  = 3'b000;
   localparam logic [2:0] I_TYPE  = 3'b001;
   localparam logic [2:0] S_TYPE  = 3'b010;
   localparam logic [2:0] SB_TYPE = 3'b011;
   localparam logic [2:0] U_TYPE  = 3'b100;
   localparam logic [2:0] UJ_TYPE = 3'b101;
   localparam logic [2:0] NOP     = 3'b110;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_LT   = 4'b1000;
   localparam logic [3:0] ALU_LTU  = 4'b1001;
   localparam logic [3:0] ALU_GE   = 4'b1010;
   localparam logic [3:0] ALU_GEU  = 4'b1011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [CTRL_W-1:0] alu_control_d;
   logic              illegal_d;

   // Base operation shared by R- and I-type arithmetic encodings.
   function automatic logic [3:0] f3_op(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_op = ALU_ADD;
         3'b001:  f3_op = ALU_SLL;
         3'b010:  f3_op = ALU_LT;
         3'b011:  f3_op = ALU_LTU;
         3'b100:  f3_op = ALU_XOR;
         3'b101:  f3_op = ALU_SRL;
         3'b110:  f3_op = ALU_OR;
         default: f3_op = ALU_AND;
      endcase
   endfunction

   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (aluop)
         R_TYPE: begin
            alu_control = f3_op(funct3);
            // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
            if (funct7 == F7_ALT && funct3 == 3'b000)
               alu_control = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101)
               alu_control = ALU_SRA;
            else if (funct7 != F7_BASE)
               illegal = 1'b1;
         end
         I_TYPE: begin
            alu_control = f3_op(funct3);
            if (funct3 == 3'b101 && funct7[5])
               alu_control = ALU_SRA;
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               illegal = 1'b1;
         end
         S_TYPE: alu_control = ALU_ADD;
         SB_TYPE: begin
            case (funct3)
               3'b000, 3'b001: alu_control = ALU_SUB;
               3'b100:         alu_control = ALU_LT;
               3'b101:         alu_control = ALU_GE;
               3'b110:         alu_control = ALU_LTU;
               3'b111:         alu_control = ALU_GEU;
               default: begin
                  alu_control = ALU_ADD;
                  illegal     = 1'b1;
               end
            endcase
         end
         U_TYPE, UJ_TYPE: alu_control = ALU_ADD;
         NOP:             alu_control = ALU_ADD;
         default: begin
            alu_control = ALU_ADD;
            illegal     = 1'b1;
         end
      endcase
   end

   // ID/EX boundary: flush inserts a bubble and wins over the stall hold.
   always_comb begin
      alu_control_d = alu_control_q;
      illegal_d     = illegal_q;
      if (flush) begin
         alu_control_d = ALU_ADD;
         illegal_d     = 1'b0;
      end else if (en) begin
         alu_control_d = alu_control;
         illegal_d     = illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_control_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         alu_control_q <= alu_control_d;
         illegal_q     <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_cu.sv
// Directed bench for alu_cu: vector table for the combinational decode,
// hand-written sequences for reset, stall and flush of the registered copy.
module tb_alu_cu;

   logic       clk;
   logic       rst_n;
   logic [2:0] aluop;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       en;
   logic       flush;
   logic [3:0] alu_control;
   logic       illegal;
   logic [3:0] alu_control_q;
   logic       illegal_q;

   int checks;
   int failures;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] exp_ctrl;
      logic       exp_ill;
   } vec_t;

   vec_t vecs[$];

   alu_cu #(.CTRL_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .aluop         (aluop),
      .funct3        (funct3),
      .funct7        (funct7),
      .en            (en),
      .flush         (flush),
      .alu_control   (alu_control),
      .illegal       (illegal),
      .alu_control_q (alu_control_q),
      .illegal_q     (illegal_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic void add(input string n, input logic [2:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [3:0] c, input logic il);
      vec_t v;
      v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.exp_ctrl = c; v.exp_ill = il;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
      aluop  = op;
      funct3 = f3;
      funct7 = f7;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      flush    = 1'b0;
      drive(3'b110, 3'b000, 7'h00);

      // R_TYPE
      add("r_add",   3'b000, 3'b000, 7'h00, 4'b0000, 1'b0);
      add("r_sub",   3'b000, 3'b000, 7'h20, 4'b0001, 1'b0);
      add("r_and",   3'b000, 3'b111, 7'h00, 4'b0010, 1'b0);
      add("r_or",    3'b000, 3'b110, 7'h00, 4'b0011, 1'b0);
      add("r_xor",   3'b000, 3'b100, 7'h00, 4'b0100, 1'b0);
      add("r_sll",   3'b000, 3'b001, 7'h00, 4'b0101, 1'b0);
      add("r_srl",   3'b000, 3'b101, 7'h00, 4'b0110, 1'b0);
      add("r_sra",   3'b000, 3'b101, 7'h20, 4'b0111, 1'b0);
      add("r_slt",   3'b000, 3'b010, 7'h00, 4'b1000, 1'b0);
      add("r_sltu",  3'b000, 3'b011, 7'h00, 4'b1001, 1'b0);
      add("r_add_f7bad", 3'b000, 3'b000, 7'h01, 4'b0000, 1'b1);
      add("r_srl_f7bad", 3'b000, 3'b101, 7'h01, 4'b0110, 1'b1);
      add("r_and_alt",   3'b000, 3'b111, 7'h20, 4'b0010, 1'b1);
      add("r_sll_alt",   3'b000, 3'b001, 7'h20, 4'b0101, 1'b1);
      // I_TYPE
      add("i_add_f7",  3'b001, 3'b000, 7'h20, 4'b0000, 1'b0);
      add("i_and",     3'b001, 3'b111, 7'h00, 4'b0010, 1'b0);
      add("i_or",      3'b001, 3'b110, 7'h00, 4'b0011, 1'b0);
      add("i_or_imm",  3'b001, 3'b110, 7'h7f, 4'b0011, 1'b0);
      add("i_xor",     3'b001, 3'b100, 7'h00, 4'b0100, 1'b0);
      add("i_sll",     3'b001, 3'b001, 7'h00, 4'b0101, 1'b0);
      add("i_srl",     3'b001, 3'b101, 7'h00, 4'b0110, 1'b0);
      add("i_sra",     3'b001, 3'b101, 7'h20, 4'b0111, 1'b0);
      add("i_sra_7f",  3'b001, 3'b101, 7'h7f, 4'b0111, 1'b0);
      add("i_srl_1f",  3'b001, 3'b101, 7'h1f, 4'b0110, 1'b0);
      add("i_slt",     3'b001, 3'b010, 7'h00, 4'b1000, 1'b0);
      add("i_sltu",    3'b001, 3'b011, 7'h00, 4'b1001, 1'b0);
      add("i_sll_bad", 3'b001, 3'b001, 7'h20, 4'b0101, 1'b1);
      // S_TYPE
      add("s_000", 3'b010, 3'b000, 7'h00, 4'b0000, 1'b0);
      add("s_001", 3'b010, 3'b001, 7'h20, 4'b0000, 1'b0);
      add("s_010", 3'b010, 3'b010, 7'h7f, 4'b0000, 1'b0);
      // SB_TYPE
      add("sb_beq",  3'b011, 3'b000, 7'h00, 4'b0001, 1'b0);
      add("sb_bne",  3'b011, 3'b001, 7'h00, 4'b0001, 1'b0);
      add("sb_blt",  3'b011, 3'b100, 7'h00, 4'b1000, 1'b0);
      add("sb_bge",  3'b011, 3'b101, 7'h00, 4'b1010, 1'b0);
      add("sb_bltu", 3'b011, 3'b110, 7'h00, 4'b1001, 1'b0);
      add("sb_bgeu", 3'b011, 3'b111, 7'h00, 4'b1011, 1'b0);
      add("sb_010",  3'b011, 3'b010, 7'h00, 4'b0000, 1'b1);
      add("sb_011",  3'b011, 3'b011, 7'h00, 4'b0000, 1'b1);
      // U/UJ/NOP/reserved
      add("u_type",  3'b100, 3'b101, 7'h7f, 4'b0000, 1'b0);
      add("uj_type", 3'b101, 3'b011, 7'h20, 4'b0000, 1'b0);
      add("nop",     3'b110, 3'b111, 7'h7f, 4'b0000, 1'b0);
      add("rsv_111", 3'b111, 3'b000, 7'h00, 4'b0000, 1'b1);
      add("rsv_111b",3'b111, 3'b101, 7'h20, 4'b0000, 1'b1);

      // Reset state, with clock running and en high.
      en = 1'b1;
      #1;
      check("reset_q", {alu_control_q, illegal_q}, 5'b0000_0);
      @(posedge clk); #1;
      check("reset_hold_q", {alu_control_q, illegal_q}, 5'b0000_0);

      // Combinational decode table.
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
         #1;
         check(vecs[i].name, {alu_control, illegal}, {vecs[i].exp_ctrl, vecs[i].exp_ill});
      end

      // Release reset, load a non-zero value, then assert reset mid-cycle.
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      drive(3'b000, 3'b111, 7'h00);
      @(posedge clk); #1;
      check("load_and", {alu_control_q, illegal_q}, 5'b0010_0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {alu_control_q, illegal_q}, 5'b0000_0);

      // Release and load R_TYPE SUB with one-cycle latency.
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b000, 3'b000, 7'h20);
      #1;
      check("sub_before_edge", {alu_control_q, illegal_q}, 5'b0000_0);
      @(posedge clk); #1;
      check("sub_after_edge", {alu_control_q, illegal_q}, 5'b0001_0);

      // Stall: en=0 holds while input changes to SRA.
      @(negedge clk);
      en = 1'b0;
      drive(3'b000, 3'b101, 7'h20);
      @(posedge clk); #1;
      check("stall_hold", {alu_control_q, illegal_q}, 5'b0001_0);
      check("stall_comb_sra", {alu_control, illegal}, 5'b0111_0);

      // Release stall and capture SRA.
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check("sra_loaded", {alu_control_q, illegal_q}, 5'b0111_0);

      // Illegal encoding travels through the register.
      @(negedge clk);
      drive(3'b111, 3'b000, 7'h00);
      @(posedge clk); #1;
      check("illegal_loaded", {alu_control_q, illegal_q}, 5'b0000_1);

      // flush with en=1 loads a bubble over an incoming SUB.
      @(negedge clk);
      drive(3'b011, 3'b000, 7'h00);
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_en1", {alu_control_q, illegal_q}, 5'b0000_0);

      // Load BGEU, then flush with en=0 must still clear.
      @(negedge clk);
      flush = 1'b0;
      drive(3'b011, 3'b111, 7'h00);
      @(posedge clk); #1;
      check("bgeu_loaded", {alu_control_q, illegal_q}, 5'b1011_0);
      @(negedge clk);
      en    = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_en0", {alu_control_q, illegal_q}, 5'b0000_0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
